// File: rtl/bus_arb_pkg.sv
// Shared constants and helpers for the bus-source arbiter and the bus mux.
package bus_arb_pkg;

    localparam int   BUS_N_SRC = 32;
    localparam int   BUS_SEL_W = 5;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/bus_prio_find.sv
// Circular lowest-set-bit search: first set bit of req at or above start, wrapping.
module bus_prio_find
    import bus_arb_pkg::*;
#(
    parameter int N_SRC = BUS_N_SRC,
    parameter int SEL_W = BUS_SEL_W
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    localparam int IW = SEL_W + 1;

    logic [N_SRC-1:0] rot;
    logic [SEL_W-1:0] off;
    logic [IW-1:0]    sum;

    always_comb begin
        // Rotate so that bit 'start' lands at position 0, then take the lowest set bit.
        rot   = N_SRC'({req, req} >> start);
        found = |rot;
        off   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
        // Un-rotate: (start + off) mod N_SRC, with both operands below N_SRC.
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= IW'(N_SRC)) sum = sum - IW'(N_SRC);
        idx = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/bus_source_arbiter.sv
// Registered bus-source arbiter: fixed-priority or round-robin grant of N_SRC
// drive requests, with multi-hot flag and saturating conflict counter.
module bus_source_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_SRC = BUS_N_SRC,
    parameter int SEL_W = BUS_SEL_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             mode_rr,
    input  logic [N_SRC-1:0] req,
    input  logic             cnt_clr,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic [N_SRC-1:0] grant,
    output logic             multi_hot,
    output logic [CNT_W-1:0] conflict_cnt
);

    if (N_SRC < 2 || N_SRC > 64 || SEL_W < clog2(N_SRC)) begin : g_param_chk
        $error("bus_source_arbiter: N_SRC must be 2..64 and SEL_W >= clog2(N_SRC)");
    end

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] start;
    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] ptr_nxt;
    logic             found;
    logic             multi;

    assign start   = (mode_rr == ARB_RR) ? ptr : '0;
    // Clearing the lowest set bit leaves something behind only if two or more were set.
    assign multi   = |(req & (req - N_SRC'(1)));
    assign ptr_nxt = (win == SEL_W'(N_SRC - 1)) ? '0 : win + 1'b1;

    bus_prio_find #(
        .N_SRC (N_SRC),
        .SEL_W (SEL_W)
    ) u_find (
        .req   (req),
        .start (start),
        .found (found),
        .idx   (win)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            sel          <= '0;
            sel_valid    <= 1'b0;
            grant        <= '0;
            multi_hot    <= 1'b0;
            conflict_cnt <= '0;
            ptr          <= '0;
        end else if (en) begin
            multi_hot <= multi;
            if (cnt_clr)
                conflict_cnt <= '0;
            else if (multi && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + 1'b1;

            sel_valid <= found;
            grant     <= found ? (N_SRC'(1) << win) : '0;
            // An idle sample keeps the last select so the mux never sees X.
            if (found) begin
                sel <= win;
                if (mode_rr == ARB_RR) ptr <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed vector table plus randomized run against a behavioural arbiter model.
module tb_bus_source_arbiter;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        clr, en, mode_rr, cnt_clr;
    logic [31:0] req;

    logic [4:0]  sel,   s_sel;
    logic        vld,   s_vld;
    logic [31:0] grant, s_grant;
    logic        mh,    s_mh;
    logic [7:0]  cnt;
    logic [1:0]  s_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    int          m_ptr, m_sel, m_cnt, m_sat;
    logic        m_vld, m_mh;
    logic [31:0] m_grant;

    always #5 clk = ~clk;

    bus_source_arbiter #(.N_SRC(32), .SEL_W(5), .CNT_W(8)) dut (
        .clk(clk), .clr(clr), .en(en), .mode_rr(mode_rr), .req(req), .cnt_clr(cnt_clr),
        .sel(sel), .sel_valid(vld), .grant(grant), .multi_hot(mh), .conflict_cnt(cnt)
    );

    bus_source_arbiter #(.N_SRC(32), .SEL_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .clr(clr), .en(en), .mode_rr(mode_rr), .req(req), .cnt_clr(cnt_clr),
        .sel(s_sel), .sel_valid(s_vld), .grant(s_grant), .multi_hot(s_mh), .conflict_cnt(s_cnt)
    );

    typedef struct {
        logic        clr, en, mode, cc;
        logic [31:0] req;
        int          sel;
        logic        vld, mh;
        int          cnt, sat;
    } vec_t;

    function automatic vec_t mk(logic c, logic e, logic m, logic cc, logic [31:0] r,
                                int s, logic v, logic h, int k, int st);
        vec_t x;
        x.clr = c; x.en = e; x.mode = m; x.cc = cc; x.req = r;
        x.sel = s; x.vld = v; x.mh = h; x.cnt = k; x.sat = st;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: arbitration rules applied directly, one sampled edge at a time.
    task automatic model_edge();
        int  start, w;
        bit  hit;
        if (clr) begin
            m_ptr = 0; m_sel = 0; m_vld = 0; m_grant = 0; m_mh = 0; m_cnt = 0; m_sat = 0;
        end else if (en) begin
            m_mh = ($countones(req) >= 2);
            if (cnt_clr) begin
                m_cnt = 0; m_sat = 0;
            end else if (m_mh) begin
                if (m_cnt < 255) m_cnt++;
                if (m_sat < 3)   m_sat++;
            end
            if (req == 0) begin
                m_vld = 0; m_grant = 0;
            end else begin
                start = mode_rr ? m_ptr : 0;
                hit = 0; w = 0;
                for (int k = 0; k < N; k++) begin
                    if (!hit && req[(start + k) % N]) begin
                        hit = 1; w = (start + k) % N;
                    end
                end
                m_sel = w; m_vld = 1; m_grant = 32'h1 << w;
                if (mode_rr) m_ptr = (w + 1) % N;
            end
        end
    endtask

    task automatic step(input logic c, input logic e, input logic m, input logic cc,
                        input logic [31:0] r);
        clr = c; en = e; mode_rr = m; cnt_clr = cc; req = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    vec_t tbl[27];

    initial begin
        logic [31:0] r;
        clr = 1'b1; en = 1'b0; mode_rr = 1'b0; cnt_clr = 1'b0; req = '0;

        tbl[0]  = mk(1,0,0,0,32'h0,          0, 0,0, 0,0);
        tbl[1]  = mk(1,0,0,0,32'h0,          0, 0,0, 0,0);
        tbl[2]  = mk(0,1,0,0,32'h0000_0010,  4, 1,0, 0,0);
        tbl[3]  = mk(0,1,0,0,32'h8000_0042,  1, 1,1, 1,1);
        tbl[4]  = mk(0,1,0,0,32'h8000_0042,  1, 1,1, 2,2);
        tbl[5]  = mk(0,1,0,0,32'h8000_0042,  1, 1,1, 3,3);
        tbl[6]  = mk(0,1,0,0,32'h8000_0042,  1, 1,1, 4,3);
        tbl[7]  = mk(0,1,1,0,32'h8000_0005,  0, 1,1, 5,3);
        tbl[8]  = mk(0,1,1,0,32'h8000_0005,  2, 1,1, 6,3);
        tbl[9]  = mk(0,1,1,0,32'h8000_0005, 31, 1,1, 7,3);
        tbl[10] = mk(0,1,1,0,32'h8000_0005,  0, 1,1, 8,3);
        tbl[11] = mk(0,1,1,0,32'h0000_0005,  2, 1,1, 9,3);
        tbl[12] = mk(0,1,1,0,32'h0,          2, 0,0, 9,3);
        tbl[13] = mk(0,0,1,0,32'h1,          2, 0,0, 9,3);
        tbl[14] = mk(0,1,1,0,32'h1,          0, 1,0, 9,3);
        tbl[15] = mk(0,1,0,1,32'h3,          0, 1,1, 0,0);
        tbl[16] = mk(0,0,0,1,32'h3,          0, 1,1, 0,0);
        tbl[17] = mk(0,1,0,0,32'h6,          1, 1,1, 1,1);
        tbl[18] = mk(0,1,0,0,32'h6,          1, 1,1, 2,2);
        tbl[19] = mk(0,1,0,0,32'h6,          1, 1,1, 3,3);
        tbl[20] = mk(0,1,0,0,32'h6,          1, 1,1, 4,3);
        tbl[21] = mk(0,1,0,0,32'h6,          1, 1,1, 5,3);
        tbl[22] = mk(0,1,1,0,32'h40,         6, 1,0, 5,3);
        tbl[23] = mk(1,1,1,0,32'hFF,         0, 0,0, 0,0);
        tbl[24] = mk(0,1,1,0,32'h81,         0, 1,1, 1,1);
        tbl[25] = mk(0,1,1,0,32'h81,         7, 1,1, 2,2);
        tbl[26] = mk(1,0,1,0,32'h81,         0, 0,0, 0,0);

        @(negedge clk);
        for (int i = 0; i < 27; i++) begin
            logic [31:0] g;
            step(tbl[i].clr, tbl[i].en, tbl[i].mode, tbl[i].cc, tbl[i].req);
            g = tbl[i].vld ? (32'h1 << tbl[i].sel) : 32'h0;
            chk($sformatf("vec%0d sel", i),       64'(sel),     64'(tbl[i].sel));
            chk($sformatf("vec%0d sel_valid", i), 64'(vld),     64'(tbl[i].vld));
            chk($sformatf("vec%0d grant", i),     64'(grant),   64'(g));
            chk($sformatf("vec%0d multi_hot", i), 64'(mh),      64'(tbl[i].mh));
            chk($sformatf("vec%0d cnt", i),       64'(cnt),     64'(tbl[i].cnt));
            chk($sformatf("vec%0d sat_cnt", i),   64'(s_cnt),   64'(tbl[i].sat));
            chk($sformatf("vec%0d sat_sel", i),   64'(s_sel),   64'(tbl[i].sel));
            chk($sformatf("vec%0d sat_grant", i), 64'(s_grant), 64'(g));
        end

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       r = 32'h0;
                1:       r = 32'h1 << $urandom_range(0, 31);
                2:       r = $urandom & $urandom & $urandom;
                default: r = $urandom;
            endcase
            step(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), r);
            chk("rnd sel",       64'(sel),     64'(m_sel));
            chk("rnd sel_valid", 64'(vld),     64'(m_vld));
            chk("rnd grant",     64'(grant),   64'(m_grant));
            chk("rnd multi_hot", 64'(mh),      64'(m_mh));
            chk("rnd cnt",       64'(cnt),     64'(m_cnt));
            chk("rnd sat_cnt",   64'(s_cnt),   64'(m_sat));
            chk("rnd sat_vld",   64'(s_vld),   64'(m_vld));
            chk("rnd sat_mh",    64'(s_mh),    64'(m_mh));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
